// File: rtl/striping_seq_pkg.sv
// Shared encodings and default byte values for the phy_tx lane striping sequencer.
package striping_seq_pkg;

    localparam logic [1:0] StSync   = 2'd0;
    localparam logic [1:0] StActive = 2'd1;
    localparam logic [1:0] StPad    = 2'd2;

    localparam logic [7:0] DefSyncByte = 8'hBC;
    localparam logic [7:0] DefPadByte  = 8'h7C;

endpackage

// File: rtl/striping_sync_gen.sv
// SYNC burst byte counter: counts emitted SYNC bytes, holds on lane stalls,
// and raises a one-cycle done pulse on the edge that emits the last byte.
module striping_sync_gen #(
    parameter int unsigned SyncLen = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic active_i,
    input  logic lane_ok_i,
    output logic emit_o,
    output logic done_o
);

    localparam int unsigned CntW = (SyncLen > 1) ? $clog2(SyncLen) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    assign emit_o = active_i && lane_ok_i;
    assign done_o = emit_o && (cnt_q == CntW'(SyncLen - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (done_o) begin
            cnt_d = '0;
        end else if (emit_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/striping_seq.sv
// Sequencer ahead of the 2-lane byte striper: SYNC bursts, alternating lane
// steering, odd-burst padding on lane 1 and periodic resync.
module striping_seq
    import striping_seq_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE     = DefSyncByte,
    parameter logic [7:0]  PAD_BYTE      = DefPadByte,
    parameter int unsigned SYNC_LEN      = 4,
    parameter int unsigned RESYNC_PERIOD = 256
) (
    input  logic        clk_2f,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [7:0]  data_in,
    input  logic        lane_ready_0,
    input  logic        lane_ready_1,
    output logic        ready_out,
    output logic        valid_out,
    output logic [7:0]  data_out,
    output logic        lane_sel,
    output logic        link_up,
    output logic [15:0] pair_cnt
);

    logic [1:0]  state_q, state_d;
    logic        valid_q, valid_d;
    logic [7:0]  data_q, data_d;
    logic        lane_sel_q, lane_sel_d;
    logic        lane_ptr_q, lane_ptr_d;
    logic        link_up_q, link_up_d;
    logic [15:0] pair_cnt_q, pair_cnt_d;
    logic [15:0] resync_cnt_q, resync_cnt_d;

    logic lane_ok;
    logic resync_due;
    logic accept;
    logic close_pair;
    logic sync_emit;
    logic sync_done;

    // lane_ptr is the lane the next byte goes to; lane_sel reports the lane of
    // data_out when valid, otherwise the lane currently being waited on.
    assign lane_ok    = lane_ptr_q ? lane_ready_1 : lane_ready_0;
    assign resync_due = (RESYNC_PERIOD != 0) && (resync_cnt_q == 16'(RESYNC_PERIOD));
    assign ready_out  = (state_q == StActive) && lane_ok && !resync_due;
    assign accept     = valid_in && ready_out;

    striping_sync_gen #(
        .SyncLen (SYNC_LEN)
    ) u_sync_gen (
        .clk_i     (clk_2f),
        .rst_ni    (reset),
        .active_i  (state_q == StSync),
        .lane_ok_i (lane_ok),
        .emit_o    (sync_emit),
        .done_o    (sync_done)
    );

    always_comb begin
        state_d      = state_q;
        valid_d      = 1'b0;
        data_d       = data_q;
        lane_ptr_d   = lane_ptr_q;
        link_up_d    = link_up_q;
        pair_cnt_d   = pair_cnt_q;
        resync_cnt_d = resync_cnt_q;
        close_pair   = 1'b0;

        case (state_q)
            StSync: begin
                if (sync_emit) begin
                    valid_d    = 1'b1;
                    data_d     = SYNC_BYTE;
                    lane_ptr_d = ~lane_ptr_q;
                end
                if (sync_done) begin
                    state_d    = StActive;
                    link_up_d  = 1'b1;
                    lane_ptr_d = 1'b0;
                end
            end
            StActive: begin
                if (resync_due && !lane_ptr_q) begin
                    state_d      = StSync;
                    resync_cnt_d = '0;
                end else if (accept) begin
                    valid_d    = 1'b1;
                    data_d     = data_in;
                    lane_ptr_d = ~lane_ptr_q;
                    close_pair = lane_ptr_q;
                end else if (lane_ptr_q && !valid_in) begin
                    state_d = StPad;
                end
            end
            StPad: begin
                if (lane_ready_1) begin
                    valid_d    = 1'b1;
                    data_d     = PAD_BYTE;
                    lane_ptr_d = 1'b0;
                    close_pair = 1'b1;
                    state_d    = StActive;
                end
            end
            default: state_d = StSync;
        endcase

        if (close_pair) begin
            pair_cnt_d   = pair_cnt_q + 16'd1;
            resync_cnt_d = resync_cnt_q + 16'd1;
        end

        lane_sel_d = valid_d ? lane_ptr_q : lane_ptr_d;
    end

    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            state_q      <= StSync;
            valid_q      <= 1'b0;
            data_q       <= 8'h00;
            lane_sel_q   <= 1'b0;
            lane_ptr_q   <= 1'b0;
            link_up_q    <= 1'b0;
            pair_cnt_q   <= 16'h0000;
            resync_cnt_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            lane_sel_q   <= lane_sel_d;
            lane_ptr_q   <= lane_ptr_d;
            link_up_q    <= link_up_d;
            pair_cnt_q   <= pair_cnt_d;
            resync_cnt_q <= resync_cnt_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign lane_sel  = lane_sel_q;
    assign link_up   = link_up_q;
    assign pair_cnt  = pair_cnt_q;

endmodule
